// File: rtl/remote_key_encoder_pkg.sv
// rtl/remote_key_encoder_pkg.sv - shared states, key codes and button indices for the remote key encoder
package remote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_SEND,
        ST_WAIT_RELEASE
    } state_e;

    localparam logic [7:0] KEY_NONE  = 8'hFF;
    localparam logic [7:0] KEY_P1_A1 = 8'h7F;
    localparam logic [7:0] KEY_P1_A2 = 8'hBF;
    localparam logic [7:0] KEY_P1_A3 = 8'hDF;
    localparam logic [7:0] KEY_P1_A4 = 8'hEF;
    localparam logic [7:0] KEY_P2_A1 = 8'hF7;
    localparam logic [7:0] KEY_P2_A2 = 8'hFB;
    localparam logic [7:0] KEY_P2_A3 = 8'hFD;
    localparam logic [7:0] KEY_P2_A4 = 8'hFE;

    localparam int BTN_P1_A1 = 7;
    localparam int BTN_P1_A2 = 6;
    localparam int BTN_P1_A3 = 5;
    localparam int BTN_P1_A4 = 4;
    localparam int BTN_P2_A1 = 3;
    localparam int BTN_P2_A2 = 2;
    localparam int BTN_P2_A3 = 1;
    localparam int BTN_P2_A4 = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/remote_key_encoder_prio_key_select.sv
// rtl/remote_key_encoder_prio_key_select.sv - picks the highest-priority pressed button as an active-low one-hot code
module prio_key_select
    import remote_pkg::*;
(
    input  logic [7:0] btn,
    output logic [7:0] key_code
);

    always_comb begin
        key_code = KEY_NONE;
        if      (btn[BTN_P1_A1]) key_code = KEY_P1_A1;
        else if (btn[BTN_P1_A2]) key_code = KEY_P1_A2;
        else if (btn[BTN_P1_A3]) key_code = KEY_P1_A3;
        else if (btn[BTN_P1_A4]) key_code = KEY_P1_A4;
        else if (btn[BTN_P2_A1]) key_code = KEY_P2_A1;
        else if (btn[BTN_P2_A2]) key_code = KEY_P2_A2;
        else if (btn[BTN_P2_A3]) key_code = KEY_P2_A3;
        else if (btn[BTN_P2_A4]) key_code = KEY_P2_A4;
    end

endmodule

// File: rtl/remote_key_encoder.sv
// rtl/remote_key_encoder.sv - debounces handset buttons and drives one prioritised answer code per press
module remote_key_encoder
    import remote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] btn_raw,
    output logic [7:0] rm_out_bcd,
    output logic       key_valid,
    output logic       busy
);

    localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, HOLD_CYCLES));
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [7:0]       snap_q, snap_d;
    logic [7:0]       out_q, out_d;
    logic             kv_q, kv_d;
    logic             busy_q, busy_d;
    logic [7:0]       sel_code;

    prio_key_select u_prio (
        .btn      (snap_q),
        .key_code (sel_code)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        snap_d  = snap_q;
        out_d   = out_q;
        kv_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_d = KEY_NONE;
                if (enable && (btn_raw != 8'h00)) begin
                    snap_d  = btn_raw;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!enable || (btn_raw != snap_q)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    out_d   = sel_code;
                    kv_d    = 1'b1;
                    hcnt_d  = '0;
                    state_d = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                // Inputs are deliberately ignored here so a started send always completes.
                if (hcnt_q == HOLD_LAST) begin
                    out_d   = KEY_NONE;
                    cnt_d   = '0;
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                out_d = KEY_NONE;
                if (btn_raw != 8'h00) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                out_d   = KEY_NONE;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            snap_q  <= '0;
            out_q   <= KEY_NONE;
            kv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            snap_q  <= snap_d;
            out_q   <= out_d;
            kv_q    <= kv_d;
            busy_q  <= busy_d;
        end
    end

    assign rm_out_bcd = out_q;
    assign key_valid  = kv_q;
    assign busy       = busy_q;

endmodule
